// File: rtl/arb_pkg.sv
// Shared types and the round-robin search for the 8-way grant arbiter.
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
// Contents: NUM_REQ/IDX_W sizing, arb_state_t FSM encoding, pick_t result, rr_pick().
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... with wrap.
    // Walk the offsets from farthest to nearest so the nearest hit overwrites.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            res;
        logic [IDX_W-1:0] j;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (req[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/idx_decoder_3_to_8.sv
// 3-bit index to 8-bit one-hot decoder.
// Latency: combinational, zero cycles.
// Backpressure: none. Ports: idx (in, 3b), onehot (out, 8b).
module idx_decoder_3_to_8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    assign onehot = 8'b0000_0001 << idx;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter granting one shared slot to 8 requesters; grant held until owner releases.
// Latency: request sampled at edge N -> registered grant visible after edge N; back-to-back handover, no bubble.
// Backpressure: in_en low blocks new grants only; optional hold limit (macro ARB_HOLD_LIMIT_EN) revokes after MAX_HOLD cycles.
// Ports: clk, rst_n (sync, active-low), in_en, in_req[7:0] -> out_gnt[7:0], out_gnt_idx[2:0], out_gnt_vld, out_revoke.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_en,
    input  logic [NUM_REQ-1:0] in_req,
    output logic [NUM_REQ-1:0] out_gnt,
    output logic [IDX_W-1:0]   out_gnt_idx,
    output logic               out_gnt_vld,
    output logic               out_revoke
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("rr_decoder_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_dec;
    logic               hold_hit;
    logic               owner_rel;
    logic               end_grant;
    logic [NUM_REQ-1:0] search_req;
    logic [IDX_W-1:0]   search_ptr;
    pick_t              pick;

    // A voluntary release excludes the leaving owner; a revoke does not, so a
    // sole revoked requester is found last (it sits just behind the new ptr).
    assign owner_rel  = (state_q == GRANT) && !in_req[idx_q];
    assign end_grant  = owner_rel || hold_hit;
    assign search_ptr = end_grant ? idx_q + IDX_W'(1) : ptr_q;
    assign search_req = owner_rel ? (in_req & ~(NUM_REQ'(1) << idx_q)) : in_req;
    assign pick       = rr_pick(search_req, search_ptr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_en && pick.found) begin
                    state_d = GRANT;
                    idx_d   = pick.idx;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    ptr_d = search_ptr;
                    if (in_en && pick.found) begin
                        idx_d = pick.idx;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // One-hot grant is registered from the next index so it always matches out_gnt_idx.
    idx_decoder_3_to_8 u_dec (
        .idx    (idx_d),
        .onehot (gnt_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= (state_d == GRANT) ? gnt_dec : '0;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             revoke_q;
    logic             cnt_clr;

    // Counter value k means the owner has held for k+1 cycles.
    assign hold_hit = (state_q == GRANT) && in_req[idx_q] &&
                      (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign cnt_clr  = (state_d == GRANT) && ((state_q == IDLE) || end_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            revoke_q <= 1'b0;
        end else begin
            revoke_q <= hold_hit;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q == GRANT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_revoke = revoke_q;
`else
    assign hold_hit   = 1'b0;
    assign out_revoke = 1'b0;
`endif

    assign out_gnt     = gnt_q;
    assign out_gnt_idx = idx_q;
    assign out_gnt_vld = (state_q == GRANT);

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: directed scenarios plus a random run against a reference model.
// Latency: expected outputs are queued when inputs are driven and compared 1 time unit after the next edge.
// Backpressure: in_en is randomised in the random phase; hold-limit scenario only when ARB_HOLD_LIMIT_EN is defined.
module tb_rr_decoder_arbiter;

    localparam int TB_MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_en = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic [7:0] out_gnt;
    logic [2:0] out_gnt_idx;
    logic       out_gnt_vld;
    logic       out_revoke;

    rr_decoder_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_en       (in_en),
        .in_req      (in_req),
        .out_gnt     (out_gnt),
        .out_gnt_idx (out_gnt_idx),
        .out_gnt_vld (out_gnt_vld),
        .out_revoke  (out_revoke)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit m_vld;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_rev;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       rev;
    } exp_t;

    exp_t sb_q[$];

    // Wait tracking, driven from observed DUT grants
    int  waits[8];
    int  max_wait;
    bit  track_wait;
    bit  prev_vld;
    int  prev_idx;

    function automatic int first_from(input logic [7:0] r, input int s);
        for (int k = 0; k < 8; k++) begin
            if (r[(s + k) % 8]) return (s + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit en, input logic [7:0] req);
        int         w;
        logic [7:0] r;
        bit         released;
        bit         revoked;
        if (!rst) begin
            m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_rev = 0;
            return;
        end
        m_rev = 0;
        if (!m_vld) begin
            if (en && req != 8'h00) begin
                m_idx = first_from(req, m_ptr);
                m_vld = 1;
                m_cnt = 0;
            end
            return;
        end
        released = !req[m_idx];
        revoked  = HOLD_EN && req[m_idx] && (m_cnt == TB_MAX_HOLD - 1);
        if (!released && !revoked) begin
            m_cnt++;
            return;
        end
        m_rev = revoked;
        m_ptr = (m_idx + 1) % 8;
        r = req;
        if (released) r[m_idx] = 1'b0;
        w = first_from(r, m_ptr);
        if (en && w >= 0) begin
            m_idx = w;
            m_cnt = 0;
        end else begin
            m_vld = 0;
            m_idx = 0;
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input logic [7:0] req);
        exp_t e;
        exp_t x;
        bit   newg;
        rst_n  = rst;
        in_en  = en;
        in_req = req;
        model_step(rst, en, req);
        e.vld = m_vld;
        e.idx = 3'(m_idx);
        e.gnt = m_vld ? (8'h01 << m_idx) : 8'h00;
        e.rev = m_rev;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk("gnt", {24'h0, out_gnt}, {24'h0, x.gnt});
        chk("idx", {29'h0, out_gnt_idx}, {29'h0, x.idx});
        chk("vld", {31'h0, out_gnt_vld}, {31'h0, x.vld});
        chk("revoke", {31'h0, out_revoke}, {31'h0, x.rev});
        chk("onehot0", {31'h0, $onehot0(out_gnt)}, 32'd1);
        if (track_wait) begin
            newg = out_gnt_vld && (!prev_vld || (int'(out_gnt_idx) != prev_idx) || out_revoke);
            for (int i = 0; i < 8; i++) begin
                if (!req[i]) waits[i] = 0;
                else if (newg) begin
                    if (i == int'(out_gnt_idx)) waits[i] = 0;
                    else waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end
            end
        end
        prev_vld = out_gnt_vld;
        prev_idx = int'(out_gnt_idx);
    endtask

    int         n_rev;
    logic [7:0] rq;
    bit         ren;

    initial begin
        track_wait = 0;
        max_wait   = 0;
        prev_vld   = 0;
        prev_idx   = 0;
        for (int i = 0; i < 8; i++) waits[i] = 0;

        // 1: reset with all requesting, then first grant goes to 0
        cyc(0, 1, 8'hFF);
        chk("rst_gnt", {24'h0, out_gnt}, 32'h00);
        chk("rst_vld", {31'h0, out_gnt_vld}, 32'd0);
        chk("rst_rev", {31'h0, out_revoke}, 32'd0);
        cyc(1, 1, 8'hFF);
        chk("t1_gnt", {24'h0, out_gnt}, 32'h01);
        chk("t1_idx", {29'h0, out_gnt_idx}, 32'd0);

        // 2: back-to-back handover and wrap-around
        cyc(0, 1, 8'h00);
        cyc(1, 1, 8'h81);
        chk("t2_first", {24'h0, out_gnt}, 32'h01);
        cyc(1, 1, 8'h80);
        chk("t2_b2b", {24'h0, out_gnt}, 32'h80);
        chk("t2_b2b_vld", {31'h0, out_gnt_vld}, 32'd1);
        cyc(1, 1, 8'h01);
        chk("t2_wrap", {24'h0, out_gnt}, 32'h01);

        // 3: in_en low blocks successor and IDLE grants
        cyc(0, 1, 8'h00);
        cyc(1, 1, 8'h24);
        chk("t3_grant2", {24'h0, out_gnt}, 32'h04);
        cyc(1, 0, 8'h24);
        chk("t3_hold", {24'h0, out_gnt}, 32'h04);
        cyc(1, 0, 8'h20);
        chk("t3_drop", {24'h0, out_gnt}, 32'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h20);
            chk("t3_ignored", {31'h0, out_gnt_vld}, 32'd0);
        end
        cyc(1, 1, 8'h20);
        chk("t3_grant5", {24'h0, out_gnt}, 32'h20);

        // 5: reset mid-grant, then arbitration restarts from ptr 0
        cyc(1, 1, 8'h20);
        cyc(0, 1, 8'h20);
        chk("t5_rst_gnt", {24'h0, out_gnt}, 32'h00);
        chk("t5_rst_vld", {31'h0, out_gnt_vld}, 32'd0);
        cyc(1, 1, 8'h21);
        chk("t5_ptr0", {24'h0, out_gnt}, 32'h01);

`ifdef ARB_HOLD_LIMIT_EN
        // 4: sole requester revoked every MAX_HOLD cycles, then handover to 6
        cyc(0, 1, 8'h00);
        n_rev = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 8'h08);
            chk("t4_sole", {24'h0, out_gnt}, 32'h08);
            if (out_revoke) n_rev++;
        end
        chk("t4_nrev", n_rev, 2);
        for (int i = 0; i < 4; i++) cyc(1, 1, 8'h48);
        chk("t4_handover", {24'h0, out_gnt}, 32'h40);
        chk("t4_rev_pulse", {31'h0, out_revoke}, 32'd1);
`endif

        // 6: random run against the model
        cyc(0, 1, 8'h00);
        track_wait = 1;
        rq = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            ren = ($urandom_range(0, 9) != 0);
            cyc(1, ren, rq);
        end
        chk("max_wait_le7", {31'h0, (max_wait <= 7)}, 32'd1);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
